// File: rtl/cache_controller.sv
// Byte-wide 2-way set-associative write-through/write-allocate cache with LRU
// replacement and an integrated backing memory. Completes one access per clock.
module cache_controller #(
    parameter int LINE_BYTES    = 16,
    parameter int NUM_SETS      = 8,
    parameter int NUM_WAYS      = 2,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] memoryAddress,
    input  logic [7:0]  writeValue,
    input  logic        isWrite,
    output logic [7:0]  outputdata,
    output logic [31:0] hitCount,
    output logic [31:0] accessCount
);

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
    localparam int MEM_BYTES = 2 ** MEM_ADDR_BITS;

    typedef logic [LINE_BYTES-1:0][7:0] line_t;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
    logic [NUM_SETS-1:0]               lru_q;     // way to evict next in each set
    logic [TAG_BITS-1:0]               tag_q  [NUM_SETS][NUM_WAYS];
    line_t                             data_q [NUM_SETS][NUM_WAYS];
    // Each byte is held XOR-ed with its own address, so an all-zero array
    // already reads back as byte i = i[7:0] without any load sequence.
    logic [7:0]                        mem_q  [MEM_BYTES] = '{default: 8'h00};
    logic [7:0]                        outputdata_q;
    logic [31:0]                       hit_count_q;
    logic [31:0]                       access_count_q;

    logic [TAG_BITS-1:0]      acc_tag;
    logic [IDX_BITS-1:0]      acc_idx;
    logic [OFF_BITS-1:0]      acc_off;
    logic [MEM_ADDR_BITS-1:0] acc_mem_addr;

    logic  hit0, hit1, hit;
    logic  way;
    line_t fill_line;
    line_t line_d;
    logic [7:0] outputdata_d;

    assign acc_tag      = memoryAddress[31 -: TAG_BITS];
    assign acc_idx      = memoryAddress[OFF_BITS +: IDX_BITS];
    assign acc_off      = memoryAddress[OFF_BITS-1:0];
    assign acc_mem_addr = memoryAddress[MEM_ADDR_BITS-1:0];

    function automatic logic [7:0] mem_read(input logic [MEM_ADDR_BITS-1:0] a);
        return mem_q[a] ^ a[7:0];
    endfunction

    // Lookup and victim choice: a hit way wins, else first invalid way, else LRU.
    always_comb begin
        hit0 = valid_q[acc_idx][0] && (tag_q[acc_idx][0] == acc_tag);
        hit1 = valid_q[acc_idx][1] && (tag_q[acc_idx][1] == acc_tag);
        hit  = hit0 | hit1;
        if (hit)                          way = hit1;
        else if (!valid_q[acc_idx][0])    way = 1'b0;
        else if (!valid_q[acc_idx][1])    way = 1'b1;
        else                              way = lru_q[acc_idx];
    end

    // The line that will sit in the chosen way after this access, with any
    // write byte merged in; the result byte is taken from that same line.
    always_comb begin
        fill_line = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            fill_line[b] = mem_read({acc_mem_addr[MEM_ADDR_BITS-1:OFF_BITS], OFF_BITS'(b)});
        end
        line_d = hit ? data_q[acc_idx][way] : fill_line;
        if (isWrite) begin
            line_d[acc_off] = writeValue;
        end
        outputdata_d = line_d[acc_off];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; only control state and counters are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q        <= '0;
            lru_q          <= '0;
            outputdata_q   <= 8'h00;
            hit_count_q    <= '0;
            access_count_q <= '0;
        end else begin
            valid_q[acc_idx][way] <= 1'b1;
            lru_q[acc_idx]        <= ~way;
            outputdata_q          <= outputdata_d;
            access_count_q        <= access_count_q + 32'd1;
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
        end
    end

    // NOTE: tag/data/memory arrays carry no reset; valid bits guard the cache
    // arrays and the backing memory must survive reset by design.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q[acc_idx][way]  <= acc_tag;
            data_q[acc_idx][way] <= line_d;
            if (isWrite) begin
                mem_q[acc_mem_addr] <= writeValue ^ acc_mem_addr[7:0];
            end
        end
    end

    assign outputdata  = outputdata_q;
    assign hitCount    = hit_count_q;
    assign accessCount = access_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random
// traffic compared against a tag-list LRU model and a flat memory array.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] memoryAddress = '0;
    logic [7:0]  writeValue = '0;
    logic        isWrite = 1'b0;
    logic [7:0]  outputdata;
    logic [31:0] hitCount;
    logic [31:0] accessCount;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents plus, per set, resident tags ordered
    // most-recent first (at most two entries).
    logic [7:0]  ref_mem [4096];
    int unsigned ref_sets [8][$];
    logic [31:0] ref_hits;
    logic [31:0] ref_acc;
    logic [7:0]  ref_out;

    logic [31:0] seq_a [6] = '{32'h02001f81, 32'h02001f71, 32'h02001f41,
                               32'h02001f51, 32'h02001f71, 32'h02001f41};
    logic [7:0]  seq_d [6] = '{8'h81, 8'h71, 8'h41, 8'h51, 8'h71, 8'h41};

    always #5 clk = ~clk;

    cache_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memoryAddress (memoryAddress),
        .writeValue    (writeValue),
        .isWrite       (isWrite),
        .outputdata    (outputdata),
        .hitCount      (hitCount),
        .accessCount   (accessCount)
    );

    task automatic model_reset();
        for (int s = 0; s < 8; s++) ref_sets[s].delete();
        ref_hits = '0;
        ref_acc  = '0;
        ref_out  = 8'h00;
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [7:0] wv);
        int unsigned tag;
        int idx;
        int pos;
        tag = int'(a[31:7]);
        idx = int'(a[6:4]);
        pos = -1;
        for (int k = 0; k < ref_sets[idx].size(); k++) begin
            if (ref_sets[idx][k] == tag) pos = k;
        end
        ref_acc = ref_acc + 1;
        if (pos >= 0) begin
            ref_hits = ref_hits + 1;
            ref_sets[idx].delete(pos);
        end
        ref_sets[idx].push_front(tag);
        if (ref_sets[idx].size() > 2) void'(ref_sets[idx].pop_back());
        if (wr) ref_mem[a[11:0]] = wv;
        ref_out = ref_mem[a[11:0]];
    endtask

    // One access: drive on the falling edge, let the rising edge sample it,
    // leave the caller 1 ns after that edge to look at the result.
    task automatic apply(input logic [31:0] a, input bit wr, input logic [7:0] wv);
        @(negedge clk);
        memoryAddress = a;
        isWrite       = wr;
        writeValue    = wv;
        model_access(a, wr, wv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] a, input bit wr, input logic [7:0] wv);
        @(negedge clk);
        rst_n         = 1'b0;
        memoryAddress = a;
        isWrite       = wr;
        writeValue    = wv;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(32'h0, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputdata: got %h expected 00", outputdata);
        end
        checks++;
        if (hitCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_hitCount: got %0d expected 0", hitCount);
        end
        checks++;
        if (accessCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_accessCount: got %0d expected 0", accessCount);
        end
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 6; i++) begin
            apply(seq_a[i], 1'b0, 8'h00);
            checks++;
            if (outputdata !== seq_d[i]) begin
                errors++;
                $display("FAIL seq_out[%0d]: got %h expected %h", i, outputdata, seq_d[i]);
            end
        end
        checks++;
        if (hitCount !== 32'd2) begin
            errors++;
            $display("FAIL seq_hitCount: got %0d expected 2", hitCount);
        end
        checks++;
        if (accessCount !== 32'd6) begin
            errors++;
            $display("FAIL seq_accessCount: got %0d expected 6", accessCount);
        end
    endtask

    // Reset asserted with a write pending: nothing may be counted or stored.
    task automatic test_reset_midrun();
        do_reset(32'h02001f41, 1'b1, 8'hEE);
        checks++;
        if (outputdata !== 8'h00 || hitCount !== 32'd0 || accessCount !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset: got out=%h hits=%0d acc=%0d expected 00/0/0",
                     outputdata, hitCount, accessCount);
        end
        apply(32'h02001f41, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h41) begin
            errors++;
            $display("FAIL midrun_reread: got %h expected 41", outputdata);
        end
        checks++;
        if (hitCount !== 32'd0 || accessCount !== 32'd1) begin
            errors++;
            $display("FAIL midrun_counts: got hits=%0d acc=%0d expected 0/1", hitCount, accessCount);
        end
    endtask

    task automatic test_read_hit();
        logic [31:0] h0;
        apply(32'h00000010, 1'b0, 8'h00);
        h0 = hitCount;
        apply(32'h00000013, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h13 || hitCount !== h0 + 32'd1) begin
            errors++;
            $display("FAIL read_hit: got out=%h hits=%0d expected 13/%0d", outputdata, hitCount, h0 + 1);
        end
    endtask

    task automatic test_write_allocate();
        logic [31:0] h0;
        apply(32'h00000020, 1'b1, 8'h5A);
        checks++;
        if (outputdata !== 8'h5A) begin
            errors++;
            $display("FAIL wr_alloc_out: got %h expected 5a", outputdata);
        end
        h0 = hitCount;
        apply(32'h00000020, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h5A || hitCount !== h0 + 32'd1) begin
            errors++;
            $display("FAIL wr_alloc_hit: got out=%h hits=%0d expected 5a/%0d", outputdata, hitCount, h0 + 1);
        end
        apply(32'h000000A0, 1'b0, 8'h00);
        apply(32'h00000120, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h20) begin
            errors++;
            $display("FAIL wr_alloc_evictor: got %h expected 20", outputdata);
        end
        h0 = hitCount;
        apply(32'h00000020, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h5A || hitCount !== h0) begin
            errors++;
            $display("FAIL wr_alloc_refetch: got out=%h hits=%0d expected 5a/%0d", outputdata, hitCount, h0);
        end
    endtask

    task automatic test_lru();
        logic [31:0] h0;
        do_reset(32'h0, 1'b0, 8'h00);
        apply(32'h00000000, 1'b0, 8'h00);
        apply(32'h00000080, 1'b0, 8'h00);
        apply(32'h00000000, 1'b0, 8'h00);
        apply(32'h00000100, 1'b0, 8'h00);
        h0 = hitCount;
        apply(32'h00000000, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h00 || hitCount !== h0 + 32'd1) begin
            errors++;
            $display("FAIL lru_keep_mru: got out=%h hits=%0d expected 00/%0d", outputdata, hitCount, h0 + 1);
        end
        apply(32'h00000080, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h80 || hitCount !== h0 + 32'd1) begin
            errors++;
            $display("FAIL lru_evicted: got out=%h hits=%0d expected 80/%0d", outputdata, hitCount, h0 + 1);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] h0;
        apply(32'h00000030, 1'b0, 8'h00);
        h0 = hitCount;
        apply(32'h00000030, 1'b1, 8'hC3);
        checks++;
        if (outputdata !== 8'hC3 || hitCount !== h0 + 32'd1) begin
            errors++;
            $display("FAIL write_hit: got out=%h hits=%0d expected c3/%0d", outputdata, hitCount, h0 + 1);
        end
        apply(32'h00000031, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h31 || hitCount !== h0 + 32'd2) begin
            errors++;
            $display("FAIL write_hit_neighbor: got out=%h hits=%0d expected 31/%0d", outputdata, hitCount, h0 + 2);
        end
    endtask

    task automatic test_back_to_back();
        apply(32'h00000345, 1'b1, 8'hA7);
        apply(32'h00000345, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'hA7) begin
            errors++;
            $display("FAIL b2b_first: got %h expected a7", outputdata);
        end
        apply(32'h00000345, 1'b1, 8'h3C);
        apply(32'h00000345, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second: got %h expected 3c", outputdata);
        end
        apply(32'h00000346, 1'b0, 8'h00);
        checks++;
        if (outputdata !== 8'h46) begin
            errors++;
            $display("FAIL b2b_neighbor: got %h expected 46", outputdata);
        end
    endtask

    // Random traffic below 4 KiB so no two cached tags alias the same memory byte.
    task automatic test_random();
        logic [31:0] a;
        bit          wr;
        logic [7:0]  wv;
        do_reset(32'h0, 1'b0, 8'h00);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 4095));
            else a = (32'($urandom_range(0, 3)) << 7) | 32'($urandom_range(0, 127));
            wr = ($urandom_range(0, 2) == 0);
            wv = 8'($urandom);
            apply(a, wr, wv);
            checks++;
            if (outputdata !== ref_out || hitCount !== ref_hits || accessCount !== ref_acc) begin
                errors++;
                $display("FAIL random[%0d] addr=%h wr=%0d: got out=%h hits=%0d acc=%0d expected %h/%0d/%0d",
                         n, a, wr, outputdata, hitCount, accessCount, ref_out, ref_hits, ref_acc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i);
        model_reset();
        test_reset();
        test_sequence();
        test_reset_midrun();
        test_read_hit();
        test_write_allocate();
        test_lru();
        test_write_hit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
